// File: rtl/serial_subtractor.sv
// serial_subtractor: digit-serial a - b - bin over WIDTH bits, DIGIT bits per clock, LSB first.
// Latency: start accepted at edge E0 -> done pulses in the cycle after edge E0+NDIG; one result per NDIG+2 cycles.
// Backpressure: none; start is ignored while busy (RUN or DONE), there is no queueing.
//
// Ports:
//   clk, rst_n         rising-edge clock, asynchronous active-low reset
//   start, a, b, bin   request and operands, sampled on the accepting edge (busy=0)
//   busy, done         busy in RUN/DONE; done is a one-cycle result-valid pulse
//   diff, bout, ovf    result, unsigned borrow-out, signed overflow (held until next done)
//
// Optional build macro SUB_SAT_EN: unsigned floor saturation (diff forced to 0 on borrow).
module serial_subtractor #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    // Only the bits that survive to the final result are kept in the result register.
    localparam int RW   = (NDIG > 1) ? (WIDTH - DIGIT) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] diff_q;
    logic             bout_q;
    logic             ovf_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [RW-1:0]    res_q;
    logic             borrow_q;
    logic [CW-1:0]    cnt_q;
    logic             a_msb_q;
    logic             b_msb_q;

    logic [DIGIT:0]   dig_d;
    logic [WIDTH-1:0] res_d;
    logic [WIDTH-1:0] diff_d;
    logic             ovf_d;
    logic             last_d;

    // One digit of subtraction; the extra top bit is the digit's borrow-out.
    assign dig_d = {1'b0, a_q[DIGIT-1:0]} - {1'b0, b_q[DIGIT-1:0]} - {{DIGIT{1'b0}}, borrow_q};

    // Full result as it would stand after this edge: new digit enters at the MSB end.
    generate
        if (NDIG == 1) begin : g_single
            assign res_d = dig_d[DIGIT-1:0];
        end else begin : g_multi
            assign res_d = {dig_d[DIGIT-1:0], res_q};
        end
    endgenerate

    assign last_d = (cnt_q == CW'(NDIG - 1));

    // Signed overflow only possible when operand signs differ; judged on the unsaturated result.
    assign ovf_d = (a_msb_q != b_msb_q) && (res_d[WIDTH-1] != a_msb_q);

`ifdef SUB_SAT_EN
    assign diff_d = dig_d[DIGIT] ? '0 : res_d;
`else
    assign diff_d = res_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q      <= a;
                        b_q      <= b;
                        borrow_q <= bin;
                        a_msb_q  <= a[WIDTH-1];
                        b_msb_q  <= b[WIDTH-1];
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= RUN;
                    end
                end
                RUN: begin
                    a_q      <= a_q >> DIGIT;
                    b_q      <= b_q >> DIGIT;
                    res_q    <= res_d[WIDTH-1:WIDTH-RW];
                    borrow_q <= dig_d[DIGIT];
                    cnt_q    <= cnt_q + CW'(1);
                    if (last_d) begin
                        diff_q  <= diff_d;
                        bout_q  <= dig_d[DIGIT];
                        ovf_q   <= ovf_d;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign diff = diff_q;
    assign bout = bout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: checks an 8/1 and an 8/4 serial_subtractor against a plain-arithmetic model.
// Latency: n/a (bench).
// Backpressure: n/a (bench).
module tb_serial_subtractor;

`ifdef SUB_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start0, start1;
    logic [7:0] a, b;
    logic       bin;
    logic       busy0, done0, bout0, ovf0;
    logic       busy1, done1, bout1, ovf1;
    logic [7:0] diff0, diff1;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8), .DIGIT(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .a(a), .b(b), .bin(bin),
        .busy(busy0), .done(done0), .diff(diff0), .bout(bout0), .ovf(ovf0)
    );

    serial_subtractor #(.WIDTH(8), .DIGIT(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a), .b(b), .bin(bin),
        .busy(busy1), .done(done1), .diff(diff1), .bout(bout1), .ovf(ovf1)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] exp_prev [2];

    typedef struct {
        int         sel;
        logic [7:0] va;
        logic [7:0] vb;
        logic       vbin;
        logic [7:0] ediff;
        logic       ebout;
        logic       eovf;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Reference: integer arithmetic and signed range test, no digit-level modelling.
    function automatic logic [9:0] model(input logic [7:0] ma, input logic [7:0] mb, input logic mbin);
        int         u, s;
        logic [7:0] d;
        logic       bo, ov;
        u  = int'(ma) - int'(mb) - int'(mbin);
        s  = int'($signed(ma)) - int'($signed(mb)) - int'(mbin);
        bo = (u < 0);
        d  = u[7:0];
        ov = (s < -128) || (s > 127);
        if (SAT && bo) d = 8'h00;
        return {d, bo, ov};
    endfunction

    function automatic logic [7:0] satv(input logic [7:0] v, input logic bo);
        return (SAT && bo) ? 8'h00 : v;
    endfunction

    // One complete operation on DUT 'sel', checking latency, busy span, result hold and results.
    task automatic run_op(input int sel, input logic [7:0] ta, input logic [7:0] tb, input logic tbin,
                          input logic [7:0] ed, input logic ebo, input logic eov, input string tag);
        int         nd, lat, bcnt;
        logic [7:0] gd;
        logic       gbo, gov;
        nd = (sel == 1) ? 2 : 8;
        lat = -1; bcnt = 0; gd = '0; gbo = 1'b0; gov = 1'b0;
        @(negedge clk);
        a = ta; b = tb; bin = tbin;
        if (sel == 1) start1 = 1'b1; else start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0; start1 = 1'b0;
        a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
        for (int k = 0; k < 40; k++) begin
            if ((sel == 1) ? busy1 : busy0) bcnt++;
            if (k == nd - 1) check({tag, " hold"}, (sel == 1) ? diff1 : diff0, exp_prev[sel]);
            if ((sel == 1) ? done1 : done0) begin
                lat = k;
                gd  = (sel == 1) ? diff1 : diff0;
                gbo = (sel == 1) ? bout1 : bout0;
                gov = (sel == 1) ? ovf1 : ovf0;
                break;
            end
            @(negedge clk);
        end
        check({tag, " latency"}, lat, nd);
        check({tag, " busy_cycles"}, bcnt, nd + 1);
        check({tag, " diff"}, gd, ed);
        check({tag, " bout"}, gbo, ebo);
        check({tag, " ovf"}, gov, eov);
        @(negedge clk);
        check({tag, " post_busy_done"}, (sel == 1) ? {busy1, done1} : {busy0, done0}, 2'b00);
        exp_prev[sel] = ed;
    endtask

    vec_t       vecs [8];
    logic [9:0] m;
    int         ndone, tfirst, tsecond, lat;
    logic [7:0] gd;

    initial begin
        rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0; a = '0; b = '0; bin = 1'b0;
        exp_prev[0] = '0; exp_prev[1] = '0;

        vecs[0] = '{0, 8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b0};
        vecs[1] = '{0, 8'h00, 8'h01, 1'b0, satv(8'hFF, 1'b1), 1'b1, 1'b0};
        vecs[2] = '{0, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
        vecs[3] = '{0, 8'h7F, 8'hFF, 1'b0, satv(8'h80, 1'b1), 1'b1, 1'b1};
        vecs[4] = '{1, 8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0};
        vecs[5] = '{1, 8'h00, 8'h00, 1'b1, satv(8'hFF, 1'b1), 1'b1, 1'b0};
        vecs[6] = '{0, 8'h80, 8'h00, 1'b1, 8'h7F, 1'b0, 1'b1};
        vecs[7] = '{1, 8'h03, 8'h02, 1'b0, 8'h01, 1'b0, 1'b0};

        #2;
        check("reset dut0 outputs", {busy0, done0, diff0, bout0, ovf0}, '0);
        check("reset dut1 outputs", {busy1, done1, diff1, bout1, ovf1}, '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++)
            run_op(vecs[i].sel, vecs[i].va, vecs[i].vb, vecs[i].vbin,
                   vecs[i].ediff, vecs[i].ebout, vecs[i].eovf, $sformatf("vec%0d", i));

        // start during RUN is ignored
        @(negedge clk);
        a = 8'h5A; b = 8'h3C; bin = 1'b0; start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        ndone = 0; lat = -1; gd = '0;
        for (int k = 0; k < 20; k++) begin
            if (k == 2) begin a = 8'hFF; b = 8'h00; start0 = 1'b1; end
            if (k == 3) start0 = 1'b0;
            if (done0) begin ndone++; if (lat < 0) begin lat = k; gd = diff0; end end
            if (k == lat + 1 && lat >= 0) check("ignored busy_after_done", busy0, 1'b0);
            @(negedge clk);
        end
        check("ignored done_count", ndone, 1);
        check("ignored latency", lat, 8);
        check("ignored diff", gd, 8'h1E);
        exp_prev[0] = 8'h1E;

        // back-to-back with start held high
        @(negedge clk);
        a = 8'h5A; b = 8'h3C; bin = 1'b0; start0 = 1'b1;
        tfirst = -1; tsecond = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done0) begin
                if (tfirst < 0) tfirst = k;
                else begin tsecond = k; start0 = 1'b0; break; end
            end
        end
        start0 = 1'b0;
        check("b2b period", tsecond - tfirst, 10);
        @(negedge clk);
        check("b2b idle_after", busy0, 1'b0);

        // asynchronous reset in the middle of RUN
        @(negedge clk);
        a = 8'h80; b = 8'h01; bin = 1'b0; start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst dut0 outputs", {busy0, done0, diff0, bout0, ovf0}, '0);
        check("midrst dut1 outputs", {busy1, done1, diff1, bout1, ovf1}, '0);
        ndone = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (k == 2) rst_n = 1'b1;
            if (done0) ndone++;
        end
        check("midrst no_done", ndone, 0);
        exp_prev[0] = '0; exp_prev[1] = '0;
        run_op(0, 8'h03, 8'h02, 1'b0, 8'h01, 1'b0, 1'b0, "post_rst");

        // randomized operations against the model
        for (int i = 0; i < 30; i++) begin
            logic [7:0] ra, rb;
            logic       rbin;
            int         rsel;
            ra = 8'($urandom); rb = 8'($urandom); rbin = 1'($urandom);
            rsel = int'($urandom_range(0, 1));
            if (i % 5 == 0) rb = ra;
            m = model(ra, rb, rbin);
            run_op(rsel, ra, rb, rbin, m[9:2], m[1], m[0], $sformatf("rnd%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Parametrised multi-cycle subtractor that computes diff = a - b - bin over WIDTH bits, DIGIT bits per clock, LSB first. A registered borrow chain links the digits.
- Start/busy/done handshake; operands are latched at start.
- Produces borrow-out and signed overflow flags.
- Sits in the arithmetic datapath as the area-lean, sequential generalisation of the single-bit full subtractor.

Parameters:
WIDTH, 8, operand/result width in bits; must be ≥ 1.
DIGIT, 1, bits processed per cycle; WIDTH % DIGIT must be 0.
NDIG (localparam), WIDTH/DIGIT, number of RUN cycles per operation.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; accepted only while busy=0
a  input  WIDTH  minuend, sampled on accepting edge
b  input  WIDTH  subtrahend, sampled on accepting edge
bin  input  1  borrow-in, sampled on accepting edge
busy  output  1  high in RUN and DONE states
done  output  1  one-cycle pulse, results valid
diff  output  WIDTH  result a - b - bin mod 2^WIDTH
bout  output  1  borrow-out (1 when a < b + bin, unsigned)
ovf  output  1  signed two's-complement overflow

Behaviour:
- One clock domain: clk. Reset rst_n is asynchronous, active-low; release is synchronised externally.
- Reset values: state=IDLE, busy=0, done=0, diff=0, bout=0, ovf=0, internal shift registers/counter/borrow=0.
- FSM has three states: IDLE, RUN, DONE.
- IDLE:
  - On an edge with start=1, latch a, b and bin (bin goes into the borrow register), set counter=0, go to RUN.
  - With start=0, stay in IDLE.
- RUN:
  - Each edge subtracts the low DIGIT bits of the operand shift registers with the borrow register.
  - The DIGIT-bit digit result shifts in at the MSB end of the result shift register.
  - The borrow register takes the digit's borrow-out; the operand registers shift right by DIGIT; counter increments.
  - On the edge where counter = NDIG-1:
    - diff <= final result.
    - bout <= final borrow.
    - ovf <= (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]), using the latched a and b.
    - Go to DONE.
- DONE: done=1 for exactly one cycle; next edge returns to IDLE unconditionally.
- Latency: if start is accepted at edge E0, done is high in the cycle following edge E0+NDIG.
  - Back-to-back throughput: one result per NDIG+2 cycles.
- start while busy=1 (RUN or DONE) is ignored; no queueing, and the in-flight operation is unaffected.
- diff/bout/ovf change only on the edge entering DONE and hold until the next such edge.
- Operand inputs may change freely after the accepting edge.
- Reset mid-operation (rst_n low in any state) aborts immediately: all outputs return to reset values and no done is generated.
- WIDTH=DIGIT degenerates to a single RUN cycle; done follows 1 cycle later.
- Arithmetic is unsigned modular; ovf interprets the operands as signed; bin is included in both flags.

Optional Feature:
Macro SUB_SAT_EN.
- Defined: unsigned floor saturation. When the final borrow is 1, diff is forced to 0 on entry to DONE; bout still reports 1 and ovf is computed from the unsaturated result.
- Undefined: diff is the wrapped modular result. No saturation logic is instantiated.

Test Plan:
1. WIDTH=8, DIGIT=1; a=0x5A, b=0x3C, bin=0, start pulse -> busy high for 9 cycles; done 8 cycles after start edge; diff=0x1E, bout=0, ovf=0.
2. WIDTH=8, DIGIT=1; a=0x00, b=0x01, bin=0 -> diff=0xFF, bout=1, ovf=0. With SUB_SAT_EN defined -> diff=0x00, bout=1.
3. WIDTH=8, DIGIT=1; a=0x80, b=0x01, bin=0 -> diff=0x7F, bout=0, ovf=1. Then a=0x7F, b=0xFF -> diff=0x80, bout=1, ovf=1.
4. WIDTH=8, DIGIT=4; a=0x10, b=0x0F, bin=1 -> done 2 cycles after start edge; diff=0x00, bout=0, ovf=0.
5. Start 0x5A-0x3C, then pulse start with a=0xFF, b=0x00 at cycle 3 of RUN -> second request ignored; single done with diff=0x1E; busy=0 the cycle after done.
6. Assert rst_n=0 asynchronously at cycle 4 of RUN -> busy, done, diff, bout and ovf go to 0 immediately; no done pulse. After release, a fresh start of 0x03-0x02 -> diff=0x01.
